sdio_cmd_host: RTL and testbench

Host-side SD command-line engine: serializes a 48-bit command frame (start, direction, index, argument, CRC7, end) onto CMD and deserializes the card's R1/R2/R3 reply, with CRC7 and framing checks and an NCR timeout. It sits directly upstream of the card model's command handler on the bench CMD wire, and downstream of the host register/FSM that issues commands. One bit moves per clock-enable strobe, so the block is agnostic to the SD clock divider.

---
 rtl/sdio_cmd_host.sv | 227 ++++++++++++++++++++++
 tb/tb_sdio_cmd_host.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_cmd_host.sv
`default_nettype none
// ============================================================================
// Module   : sdio_cmd_host
// Brief    : SD host CMD-line engine; sends a 48-bit command frame and
//            receives the R1/R2/R3 reply with framing, CRC7 and NCR checks.
//            Optional: SDIO_CMD_RSP_CRC_EN enables receive CRC7 checking.
// Revision : 1.0
// ============================================================================
module sdio_cmd_host #(
    parameter int NCR_MAX = 64,
    parameter int NCC_MIN = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_ckstb,
    input  logic         i_request,
    input  logic [1:0]   i_rsp_type,
    input  logic [5:0]   i_cmd,
    input  logic [31:0]  i_arg,
    output logic         o_busy,
    output logic         o_cmd_en,
    output logic         o_cmd,
    input  logic         i_cmd_in,
    output logic         o_rsp_valid,
    output logic         o_rsp_timeout,
    output logic         o_rsp_err,
    output logic [5:0]   o_rsp_cmd,
    output logic [119:0] o_rsp_arg
);

    localparam int c_TMAX = (NCR_MAX > NCC_MIN) ? NCR_MAX : NCC_MIN;
    localparam int c_TW   = $clog2(c_TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TX   = 3'd1,
        S_WAIT = 3'd2,
        S_RX   = 3'd3,
        S_NCC  = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_cmd_en;
    logic              r_cmd_o;
    logic              r_rsp_valid;
    logic              r_rsp_timeout;
    logic              r_rsp_err;
    logic [5:0]        r_rsp_cmd;
    logic [119:0]      r_rsp_arg;
    logic [1:0]        r_rsp_type;
    logic [5:0]        r_cmd;
    logic [39:0]       r_tx_sr;
    logic [7:0]        r_bit_cnt;
    logic [c_TW-1:0]   r_tmr;
    logic [6:0]        r_crc;
    logic [133:0]      r_rx_sr;

    function automatic logic [6:0] f_crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    logic         w_is_r2;
    logic [7:0]   w_rx_last;
    logic [134:0] w_rx_next;
    logic [5:0]   w_idx;
    logic         w_dir_ok;
    logic         w_idx_ok;
    logic         w_end_ok;
    logic         w_crc_ok;
    logic         w_rx_err;

    assign w_is_r2   = (r_rsp_type == 2'b10);
    assign w_rx_last = w_is_r2 ? 8'd134 : 8'd46;
    assign w_rx_next = {r_rx_sr, i_cmd_in};
    assign w_idx     = w_is_r2 ? w_rx_next[133:128] : w_rx_next[45:40];
    assign w_dir_ok  = w_is_r2 ? ~w_rx_next[134] : ~w_rx_next[46];
    assign w_idx_ok  = (r_rsp_type == 2'b01) ? (w_idx == r_cmd) : (w_idx == 6'h3f);
    assign w_end_ok  = w_rx_next[0];

`ifdef SDIO_CMD_RSP_CRC_EN
    // R1 covers frame bits 46:8 (start bit adds nothing to a zero CRC); R2 covers 127:8
    logic w_crc_feed;
    assign w_crc_feed = w_is_r2 ? ((r_bit_cnt >= 8'd7) && (r_bit_cnt <= 8'd126))
                                : (r_bit_cnt <= 8'd38);
    assign w_crc_ok   = (r_rsp_type == 2'b11) || (r_crc == w_rx_next[7:1]);
`else
    logic w_unused_crc;
    assign w_unused_crc = ^w_rx_next[7:1];
    assign w_crc_ok     = 1'b1;
`endif

    assign w_rx_err = ~(w_dir_ok & w_idx_ok & w_end_ok & w_crc_ok);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_cmd_en      <= 1'b0;
            r_cmd_o       <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_cmd     <= 6'd0;
            r_rsp_arg     <= 120'd0;
            r_rsp_type    <= 2'b00;
            r_cmd         <= 6'd0;
            r_tx_sr       <= 40'd0;
            r_bit_cnt     <= 8'd0;
            r_tmr         <= '0;
            r_crc         <= 7'd0;
            r_rx_sr       <= 134'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // busy stays high through the valid pulse and drops one cycle later
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (i_request) begin
                        r_busy        <= 1'b1;
                        r_rsp_type    <= i_rsp_type;
                        r_cmd         <= i_cmd;
                        r_tx_sr       <= {1'b0, 1'b1, i_cmd, i_arg};
                        r_bit_cnt     <= 8'd0;
                        r_crc         <= 7'd0;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_err     <= 1'b0;
                        r_rsp_cmd     <= 6'd0;
                        r_rsp_arg     <= 120'd0;
                        r_state       <= S_TX;
                    end
                end
                S_TX: begin
                    if (i_ckstb) begin
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                        if (r_bit_cnt < 8'd40) begin
                            r_cmd_en <= 1'b1;
                            r_cmd_o  <= r_tx_sr[39];
                            r_tx_sr  <= {r_tx_sr[38:0], 1'b0};
                            r_crc    <= f_crc7_step(r_crc, r_tx_sr[39]);
                        end else if (r_bit_cnt < 8'd47) begin
                            r_cmd_o <= r_crc[6];
                            r_crc   <= {r_crc[5:0], 1'b0};
                        end else if (r_bit_cnt == 8'd47) begin
                            r_cmd_o <= 1'b1;
                        end else begin
                            r_cmd_en  <= 1'b0;
                            r_cmd_o   <= 1'b1;
                            r_bit_cnt <= 8'd0;
                            r_crc     <= 7'd0;
                            if (r_rsp_type != 2'b00) begin
                                r_tmr   <= '0;
                                r_state <= S_WAIT;
                            end else if (NCC_MIN <= 1) begin
                                r_rsp_valid <= 1'b1;
                                r_state     <= S_IDLE;
                            end else begin
                                // the release strobe already counts as one idle strobe
                                r_tmr   <= c_TW'(1);
                                r_state <= S_NCC;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (i_ckstb) begin
                        if (!i_cmd_in) begin
                            r_bit_cnt <= 8'd0;
                            r_crc     <= 7'd0;
                            r_state   <= S_RX;
                        end else if (r_tmr >= c_TW'(NCR_MAX - 1)) begin
                            r_rsp_timeout <= 1'b1;
                            r_tmr         <= '0;
                            r_state       <= S_NCC;
                        end else begin
                            r_tmr <= r_tmr + c_TW'(1);
                        end
                    end
                end
                S_RX: begin
                    if (i_ckstb) begin
                        r_rx_sr   <= w_rx_next[133:0];
                        r_bit_cnt <= r_bit_cnt + 8'd1;
`ifdef SDIO_CMD_RSP_CRC_EN
                        if (w_crc_feed) begin
                            r_crc <= f_crc7_step(r_crc, i_cmd_in);
                        end
`endif
                        if (r_bit_cnt == w_rx_last) begin
                            r_rsp_err <= w_rx_err;
                            r_rsp_cmd <= w_idx;
                            r_rsp_arg <= w_is_r2 ? w_rx_next[127:8]
                                                 : {88'd0, w_rx_next[39:8]};
                            r_tmr     <= '0;
                            r_state   <= S_NCC;
                        end
                    end
                end
                S_NCC: begin
                    if (i_ckstb) begin
                        if (r_tmr >= c_TW'(NCC_MIN - 1)) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_tmr <= r_tmr + c_TW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_cmd_en      = r_cmd_en;
    assign o_cmd         = r_cmd_o;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_cmd     = r_rsp_cmd;
    assign o_rsp_arg     = r_rsp_arg;

endmodule
`default_nettype wire

// File: tb/tb_sdio_cmd_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdio_cmd_host
// Brief    : Directed self-checking bench for sdio_cmd_host with a bit-level
//            card model driving replies on the CMD input.
// Revision : 1.0
// ============================================================================
module tb_sdio_cmd_host;

    localparam int c_NCR = 20;
    localparam int c_NCC = 5;
`ifdef SDIO_CMD_RSP_CRC_EN
    localparam logic c_CRC_ERR = 1'b1;
`else
    localparam logic c_CRC_ERR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         ckstb;
    logic         request;
    logic [1:0]   rsp_type;
    logic [5:0]   cmd;
    logic [31:0]  arg;
    logic         busy;
    logic         cmd_en;
    logic         cmd_out;
    logic         cmd_in;
    logic         rsp_valid;
    logic         rsp_timeout;
    logic         rsp_err;
    logic [5:0]   rsp_cmd;
    logic [119:0] rsp_arg;

    int   errors = 0;
    int   checks = 0;
    logic seen_valid;
    logic busy_at_valid;

    always #5 clk = ~clk;

    sdio_cmd_host #(.NCR_MAX(c_NCR), .NCC_MIN(c_NCC)) dut (
        .i_clk(clk), .i_reset(reset), .i_ckstb(ckstb), .i_request(request),
        .i_rsp_type(rsp_type), .i_cmd(cmd), .i_arg(arg), .o_busy(busy),
        .o_cmd_en(cmd_en), .o_cmd(cmd_out), .i_cmd_in(cmd_in),
        .o_rsp_valid(rsp_valid), .o_rsp_timeout(rsp_timeout), .o_rsp_err(rsp_err),
        .o_rsp_cmd(rsp_cmd), .o_rsp_arg(rsp_arg)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [135:0] d, input int n);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic strobe(input logic line, input int gap);
        cmd_in = line;
        ckstb  = 1'b1;
        @(posedge clk);
        #1;
        ckstb         = 1'b0;
        seen_valid    = rsp_valid;
        busy_at_valid = busy;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] t, input logic [5:0] idx, input logic [31:0] a);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        rsp_type = t;
        cmd      = idx;
        arg      = a;
        request  = 1'b1;
        @(posedge clk);
        #1;
        request = 1'b0;
        check("accept_busy", busy, 1'b1);
    endtask

    task automatic send_frame(input logic [1:0] t, input logic [5:0] idx,
                              input logic [31:0] a, output logic [47:0] frame);
        logic en_bad;
        issue(t, idx, a);
        en_bad = 1'b0;
        frame  = 48'd0;
        for (int k = 0; k < 48; k++) begin
            strobe(1'b1, k % 3);
            frame = {frame[46:0], cmd_out};
            if (!cmd_en) en_bad = 1'b1;
            if (k == 10) begin
                // a request while busy must not disturb the frame in flight
                request = 1'b1;
                cmd     = 6'd63;
                arg     = 32'hdead_beef;
                @(posedge clk);
                #1;
                request = 1'b0;
            end
        end
        check("tx_drive_en", en_bad, 1'b0);
        strobe(1'b1, 0);
        check("tx_release", cmd_en, 1'b0);
    endtask

    task automatic card_reply(input logic [135:0] bits, input int n);
        strobe(1'b1, 1);
        strobe(1'b1, 0);
        for (int i = n - 1; i >= 0; i--) strobe(bits[i], i % 2);
    endtask

    task automatic wait_valid(output int cnt);
        cnt        = 0;
        seen_valid = 1'b0;
        while (!seen_valid && cnt < 200) begin
            strobe(1'b1, 0);
            cnt++;
        end
        check("valid_seen", seen_valid, 1'b1);
        check("busy_during_valid", busy_at_valid, 1'b1);
        request = 1'b1;
        cmd     = 6'd1;
        @(posedge clk);
        #1;
        request = 1'b0;
        check("req_at_valid_ignored", busy, 1'b0);
    endtask

    logic [47:0]  frame;
    logic [135:0] resp;
    logic [119:0] cid;
    logic [119:0] cid_bad;
    int           n;

    initial begin
        reset    = 1'b1;
        ckstb    = 1'b0;
        request  = 1'b0;
        rsp_type = 2'b00;
        cmd      = 6'd0;
        arg      = 32'd0;
        cmd_in   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_en", cmd_en, 1'b0);
        check("rst_cmd", cmd_out, 1'b1);
        check("rst_flags", {rsp_valid, rsp_timeout, rsp_err}, 3'b000);
        check("rst_rsp_data", {rsp_cmd, rsp_arg}, 126'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // CMD0, no response
        send_frame(2'b00, 6'd0, 32'd0, frame);
        check("cmd0_frame", frame, 48'h40_0000_0000_95);
        wait_valid(n);
        check("cmd0_ncc", n, c_NCC - 1);
        check("cmd0_flags", {rsp_timeout, rsp_err}, 2'b00);

        // CMD8 with R1 echo
        send_frame(2'b01, 6'd8, 32'h1AA, frame);
        check("cmd8_frame", frame, 48'h48_0000_01AA_87);
        resp = {88'd0, 2'b00, 6'd8, 32'h1AA, crc7({2'b00, 6'd8, 32'h1AA}, 40), 1'b1};
        card_reply(resp, 48);
        wait_valid(n);
        check("cmd8_ncc", n, c_NCC);
        check("cmd8_rsp_cmd", rsp_cmd, 6'd8);
        check("cmd8_rsp_arg", rsp_arg, 120'h1AA);
        check("cmd8_flags", {rsp_timeout, rsp_err}, 2'b00);

        // ACMD41 with R3, CRC field is garbage and must be ignored
        send_frame(2'b11, 6'd41, 32'h40ff_8000, frame);
        check("acmd41_frame", frame,
              {2'b01, 6'd41, 32'h40ff_8000, crc7({2'b01, 6'd41, 32'h40ff_8000}, 40), 1'b1});
        resp = {88'd0, 2'b00, 6'h3f, 32'h80ff_8000, 7'h55, 1'b1};
        card_reply(resp, 48);
        wait_valid(n);
        check("acmd41_rsp_arg", rsp_arg, 120'h80ff_8000);
        check("acmd41_rsp_cmd", rsp_cmd, 6'h3f);
        check("acmd41_err", rsp_err, 1'b0);

        // CMD2 with R2 CID, valid CRC
        cid = 120'h0353_4453_5531_3647_8012_3456_7801_65;
        send_frame(2'b10, 6'd2, 32'd0, frame);
        check("cmd2_frame", frame, {2'b01, 6'd2, 32'd0, crc7({2'b01, 6'd2, 32'd0}, 40), 1'b1});
        resp = {2'b00, 6'h3f, cid, crc7({16'd0, cid}, 120), 1'b1};
        card_reply(resp, 136);
        wait_valid(n);
        check("cmd2_ncc", n, c_NCC);
        check("cmd2_cid", rsp_arg, cid);
        check("cmd2_err", rsp_err, 1'b0);

        // CMD2 again with one CID bit flipped under the original CRC
        cid_bad = cid ^ (120'd1 << 37);
        send_frame(2'b10, 6'd2, 32'd0, frame);
        resp = {2'b00, 6'h3f, cid_bad, crc7({16'd0, cid}, 120), 1'b1};
        card_reply(resp, 136);
        wait_valid(n);
        check("cmd2_bad_cid", rsp_arg, cid_bad);
        check("cmd2_bad_err", rsp_err, c_CRC_ERR);

        // R1 with the wrong index is a framing error in every build
        send_frame(2'b01, 6'd8, 32'h1AA, frame);
        resp = {88'd0, 2'b00, 6'd9, 32'h1AA, crc7({2'b00, 6'd9, 32'h1AA}, 40), 1'b1};
        card_reply(resp, 48);
        wait_valid(n);
        check("bad_idx_err", rsp_err, 1'b1);

        // R1 with end bit low
        send_frame(2'b01, 6'd8, 32'h1AA, frame);
        resp = {88'd0, 2'b00, 6'd8, 32'h1AA, crc7({2'b00, 6'd8, 32'h1AA}, 40), 1'b0};
        card_reply(resp, 48);
        wait_valid(n);
        check("bad_end_err", rsp_err, 1'b1);

        // CMD17 with no card reply
        send_frame(2'b01, 6'd17, 32'd0, frame);
        wait_valid(n);
        check("cmd17_strobes", n, c_NCR + c_NCC);
        check("cmd17_timeout", rsp_timeout, 1'b1);
        check("cmd17_err", rsp_err, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("timeout_hold", rsp_timeout, 1'b1);

        // asynchronous reset in the middle of a command frame
        issue(2'b01, 6'd8, 32'h1AA);
        check("accept_clears_flags", {rsp_timeout, rsp_err}, 2'b00);
        for (int k = 0; k < 20; k++) strobe(1'b0, 0);
        check("mid_tx_drive", cmd_en, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_cmd_en", cmd_en, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_valid", rsp_valid, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_frame(2'b00, 6'd0, 32'd0, frame);
        check("post_rst_frame", frame, 48'h40_0000_0000_95);
        wait_valid(n);
        check("post_rst_ncc", n, c_NCC - 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
